// File: rtl/weight_buffer_loader.sv
// weight_buffer_loader: packs a stream of narrow weights into wide buffer writes.
// Optional WEIGHT_LOADER_PERF_EN adds a stall_count port counting input-starved LOAD cycles.
module weight_buffer_loader #(
  parameter int IN_WIDTH      = 16,
  parameter int WR_WIDTH      = 64,
  parameter int WR_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WR_ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]     num_elems,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  input  logic [IN_WIDTH-1:0]      in_data,
  output logic                     in_ready,
  output logic                     write_req,
  output logic [WR_WIDTH-1:0]      write_data,
  output logic [WR_ADDR_WIDTH-1:0] write_addr
`ifdef WEIGHT_LOADER_PERF_EN
  ,output logic [CNT_WIDTH-1:0]    stall_count
`endif
);
  localparam int RATIO = WR_WIDTH / IN_WIDTH;
  localparam int LW = $clog2(RATIO);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state_q, state_d;
  logic [WR_WIDTH-1:0] pack_q, pack_d, packed_w, write_data_q, write_data_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [WR_ADDR_WIDTH-1:0] addr_q, addr_d, write_addr_q, write_addr_d;
  logic write_req_q, write_req_d, hs, go;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign in_ready = state_q == LOAD;
  assign write_req = write_req_q;
  assign write_data = write_data_q;
  assign write_addr = write_addr_q;
  assign hs = in_valid && in_ready;
  assign go = state_q == IDLE && start;
  always_comb begin
    state_d = state_q;
    pack_d = pack_q;
    lane_d = lane_q;
    rem_d = rem_q;
    addr_d = addr_q;
    write_req_d = 1'b0;
    write_data_d = write_data_q;
    write_addr_d = write_addr_q;
    packed_w = pack_q;
    packed_w[lane_q*IN_WIDTH +: IN_WIDTH] = in_data;
    if (go) begin
      state_d = num_elems != '0 ? LOAD : DONE;
      addr_d = base_addr;
      rem_d = num_elems;
      lane_d = '0;
      pack_d = '0;
    end
    if (state_q == DONE) state_d = IDLE;
    if (hs) begin
      pack_d = packed_w;
      lane_d = lane_q + LW'(1);
      rem_d = rem_q - CNT_WIDTH'(1);
      // a word goes out when its last lane fills or the job runs out of elements
      if (lane_q == LAST_LANE || rem_q == CNT_WIDTH'(1)) begin
        write_req_d = 1'b1;
        write_data_d = packed_w;
        write_addr_d = addr_q;
        pack_d = '0;
        addr_d = addr_q + WR_ADDR_WIDTH'(1);
        lane_d = '0;
      end
      if (rem_q == CNT_WIDTH'(1)) state_d = DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pack_q <= '0;
      lane_q <= '0;
      rem_q <= '0;
      addr_q <= '0;
      write_req_q <= 1'b0;
      write_data_q <= '0;
      write_addr_q <= '0;
    end else begin
      state_q <= state_d;
      pack_q <= pack_d;
      lane_q <= lane_d;
      rem_q <= rem_d;
      addr_q <= addr_d;
      write_req_q <= write_req_d;
      write_data_q <= write_data_d;
      write_addr_q <= write_addr_d;
    end
  end
`ifdef WEIGHT_LOADER_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  assign stall_count = stall_q;
  always_comb begin
    stall_d = stall_q;
    if (go) stall_d = '0;
    else if (state_q == LOAD && !in_valid && stall_q != '1) stall_d = stall_q + CNT_WIDTH'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
`endif
endmodule

// File: tb/tb_weight_buffer_loader.sv
// tb_weight_buffer_loader: directed jobs with a write scoreboard for weight_buffer_loader.
module tb_weight_buffer_loader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [4:0] base_addr = '0;
  logic [15:0] num_elems = '0, in_data = '0;
  logic busy, done, in_ready, write_req;
  logic [63:0] write_data;
  logic [4:0] write_addr;
  logic [15:0] stall_count;
  int passed = 0, total = 0, wr_cnt = 0;
  bit n_zero_job = 1'b0;
  logic [69:0] exp_q[$];
  always #5 clk = ~clk;
  weight_buffer_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_elems(num_elems),
    .busy(busy), .done(done), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .write_req(write_req), .write_data(write_data), .write_addr(write_addr)
`ifdef WEIGHT_LOADER_PERF_EN
    , .stall_count(stall_count)
`endif
  );
`ifndef WEIGHT_LOADER_PERF_EN
  assign stall_count = '0;
`endif
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic push_job(input int base, input int n, input logic [15:0] first);
    for (int w = 0; w * 4 < n; w++) begin
      logic [63:0] d = '0;
      for (int l = 0; l < 4; l++)
        if (w * 4 + l < n) d[l*16 +: 16] = 16'(first + 16'(w * 4 + l));
      exp_q.push_back({(w + 1) * 4 >= n, 5'(base + w), d});
    end
  endtask
  task automatic start_job(input int base, input int n);
    @(negedge clk);
    start = 1'b1;
    base_addr = 5'(base);
    num_elems = 16'(n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic feed(input int n, input bit gaps, input logic [15:0] first, output int cyc);
    int i = 0;
    cyc = 0;
    while (i < n && cyc < 200) begin
      @(negedge clk);
      in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      in_data = 16'(first + 16'(i));
      if (in_valid && in_ready) i++;
      cyc++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("feed_accepts", 64'(i), 64'(n));
  endtask
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 8);
    chk("done_seen", 64'(done), 64'd1);
  endtask
  task automatic finish_job(input int writes_before, input int exp_writes);
    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("write_count", 64'(wr_cnt - writes_before), 64'(exp_writes));
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (write_req) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
        else begin
          logic [69:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(write_addr), 64'(e[68:64]));
          chk("wr_data", write_data, e[63:0]);
          chk("wr_done", 64'(done), 64'(e[69]));
        end
      end else if (done) chk("done_without_write", 64'(n_zero_job), 64'd1);
    end
  end
  initial begin
    int cyc, k, w0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_write_req", 64'(write_req), 64'd0);
    chk("rst_write_data", write_data, 64'd0);
    chk("rst_write_addr", 64'(write_addr), 64'd0);
    // Test 1: base 3, 8 elements back to back
    w0 = wr_cnt;
    push_job(3, 8, 16'h0001);
    start_job(3, 8);
    feed(8, 1'b0, 16'h0001, cyc);
    chk("t1_accept_cycles", 64'(cyc), 64'd8);
    wait_done(k);
    finish_job(w0, 2);
    // Test 2: partial final word
    w0 = wr_cnt;
    push_job(0, 5, 16'h0001);
    start_job(0, 5);
    feed(5, 1'b0, 16'h0001, cyc);
    wait_done(k);
    finish_job(w0, 2);
    // Test 3: address wrap 31 -> 0
    w0 = wr_cnt;
    push_job(31, 8, 16'h0101);
    start_job(31, 8);
    feed(8, 1'b0, 16'h0101, cyc);
    wait_done(k);
    finish_job(w0, 2);
    // Test 4: in_valid toggling
    w0 = wr_cnt;
    push_job(3, 8, 16'h0001);
    start_job(3, 8);
    feed(8, 1'b1, 16'h0001, cyc);
    chk("t4_cycles", 64'(cyc), 64'd15);
    wait_done(k);
    finish_job(w0, 2);
`ifdef WEIGHT_LOADER_PERF_EN
    chk("t4_stall_count", 64'(stall_count), 64'd7);
`endif
    // Test 5a: zero-length job
    w0 = wr_cnt;
    n_zero_job = 1'b1;
    start_job(0, 0);
    wait_done(k);
    chk("t5_done_latency", 64'(k), 64'd1);
    chk("t5_no_write", 64'(write_req), 64'd0);
    finish_job(w0, 0);
    n_zero_job = 1'b0;
    // Test 5b: start pulsed mid-job is ignored
    w0 = wr_cnt;
    push_job(8, 4, 16'h0031);
    start_job(8, 4);
    @(negedge clk);
    start = 1'b1;
    base_addr = 5'd20;
    num_elems = 16'd1;
    @(posedge clk);
    #1 start = 1'b0;
    feed(4, 1'b0, 16'h0031, cyc);
    wait_done(k);
    finish_job(w0, 1);
    // Test 6: reset mid-job drops the partial word
    w0 = wr_cnt;
    start_job(5, 8);
    feed(3, 1'b0, 16'h00aa, cyc);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_write_req", 64'(write_req), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_no_write", 64'(wr_cnt - w0), 64'd0);
    w0 = wr_cnt;
    push_job(0, 4, 16'h0021);
    start_job(0, 4);
    feed(4, 1'b0, 16'h0021, cyc);
    wait_done(k);
    finish_job(w0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
